// File: rtl/uart_cmd_tx_pkg.sv
// Shared opcodes, config bit positions and FSM state encoding for the
// command-driven UART transmitter.
package uart_pkg;

    localparam logic [1:0] CMD_DATA   = 2'd0;
    localparam logic [1:0] CMD_CONFIG = 2'd1;
    localparam logic [1:0] CMD_PREDIV = 2'd2;
    localparam logic [1:0] CMD_SPARE  = 2'd3;

    localparam logic [4:0] CMD_CONFIG_RESET = 5'b11000;

    localparam int CFG_PARITY_EN  = 0;
    localparam int CFG_PARITY_ODD = 1;
    localparam int CFG_TWO_STOP   = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } tx_state_e;

endpackage

// File: rtl/uart_cmd_tx_fifo.sv
// Synchronous FIFO with occupancy count and a flush that empties it in one
// cycle. DEPTH must be a power of two so the pointers wrap naturally.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      count_q;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rdPtr_q];
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            if (doPush && !doPop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (doPop && !doPush) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_cmd_tx.sv
// Command-port UART transmitter: DATA/CONFIG/PREDIV commands feed a TX FIFO
// and frame settings. Define UART_BREAK_EN to build the SPARE-opcode break generator.
module uart_cmd_tx
    import uart_pkg::*;
#(
    parameter int                  DATA_W     = 8,
    parameter int                  DEPTH      = 4,
    parameter int                  PREDIV_W   = 8,
    parameter logic [PREDIV_W-1:0] PREDIV_RST = PREDIV_W'(3)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [1:0]               cmd_op_i,
    input  logic [DATA_W-1:0]        cmd_payload_i,
    output logic                     txd_o,
    output logic                     busy_o,
    output logic [$clog2(DEPTH):0]   fifo_count_o,
    output logic                     reset_strobe_o
);
    localparam int CNT_W = $clog2(DATA_W + 3);

    tx_state_e           state_q, state_d;
    logic [2:0]          cfg_q, frameCfg_q, frameCfg_d;
    logic [PREDIV_W-1:0] prediv_q, framePrediv_q, framePrediv_d;
    logic [PREDIV_W-1:0] baudCnt_q, baudCnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]    bitCnt_q, bitCnt_d;
    logic                parity_q, parity_d;
    logic                strobe_q;
    logic                fifoFull, fifoEmpty;
    logic [DATA_W-1:0]   fifoHead;
    logic                accept, push, pop, softReset, breakReq, baudTick;

    assign cmd_ready_o    = !((cmd_op_i == CMD_DATA) && fifoFull);
    assign accept         = cmd_valid_i && cmd_ready_o;
    assign push           = accept && (cmd_op_i == CMD_DATA);
    assign softReset      = accept && (cmd_op_i == CMD_CONFIG)
                            && (cmd_payload_i[DATA_W-1 -: 5] == CMD_CONFIG_RESET);
    assign baudTick       = (baudCnt_q == '0);
    assign reset_strobe_o = strobe_q;
    assign busy_o         = (state_q != IDLE) || (fifo_count_o != '0);

    uart_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (softReset),
        .push_i  (push),
        .wdata_i (cmd_payload_i),
        .pop_i   (pop),
        .rdata_o (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifo_count_o)
    );

`ifdef UART_BREAK_EN
    logic breakPending_q;

    // A pending break is consumed on the IDLE cycle that enters BREAK.
    always_ff @(posedge clk) begin
        if (reset || softReset) begin
            breakPending_q <= 1'b0;
        end else if (accept && (cmd_op_i == CMD_SPARE) && cmd_payload_i[0]) begin
            breakPending_q <= 1'b1;
        end else if (state_q == IDLE) begin
            breakPending_q <= 1'b0;
        end
    end

    assign breakReq = breakPending_q;
`else
    assign breakReq = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset || softReset) begin
            cfg_q    <= '0;
            prediv_q <= PREDIV_RST;
        end else if (accept && (cmd_op_i == CMD_CONFIG)) begin
            cfg_q    <= cmd_payload_i[2:0];
        end else if (accept && (cmd_op_i == CMD_PREDIV)) begin
            prediv_q <= PREDIV_W'(cmd_payload_i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= softReset;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || softReset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frameCfg_q    <= '0;
            framePrediv_q <= PREDIV_RST;
            baudCnt_q     <= '0;
            shift_q       <= '0;
            bitCnt_q      <= '0;
            parity_q      <= 1'b0;
        end else begin
            frameCfg_q    <= frameCfg_d;
            framePrediv_q <= framePrediv_d;
            baudCnt_q     <= baudCnt_d;
            shift_q       <= shift_d;
            bitCnt_q      <= bitCnt_d;
            parity_q      <= parity_d;
        end
    end

    // Frame settings are snapshotted on leaving IDLE so mid-frame writes wait a frame.
    always_comb begin
        state_d       = state_q;
        frameCfg_d    = frameCfg_q;
        framePrediv_d = framePrediv_q;
        shift_d       = shift_q;
        bitCnt_d      = bitCnt_q;
        parity_d      = parity_q;
        baudCnt_d     = baudTick ? framePrediv_q : baudCnt_q - PREDIV_W'(1);
        unique case (state_q)
            IDLE: begin
                baudCnt_d = prediv_q;
                bitCnt_d  = '0;
                if (breakReq) begin
                    state_d       = BREAK;
                    framePrediv_d = prediv_q;
                end else if (pop) begin
                    state_d       = START;
                    shift_d       = fifoHead;
                    parity_d      = (^fifoHead) ^ cfg_q[CFG_PARITY_ODD];
                    frameCfg_d    = cfg_q;
                    framePrediv_d = prediv_q;
                end
            end
            START: begin
                if (baudTick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baudTick) begin
                    shift_d = shift_q >> 1;
                    if (bitCnt_q == CNT_W'(DATA_W - 1)) begin
                        bitCnt_d = '0;
                        state_d  = frameCfg_q[CFG_PARITY_EN] ? PARITY : STOP;
                    end else begin
                        bitCnt_d = bitCnt_q + CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (baudTick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (baudTick) begin
                    if (frameCfg_q[CFG_TWO_STOP] && (bitCnt_q == '0)) begin
                        bitCnt_d = CNT_W'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
`ifdef UART_BREAK_EN
            BREAK: begin
                if (baudTick) begin
                    if (bitCnt_q == CNT_W'(DATA_W + 2)) begin
                        state_d = IDLE;
                    end else begin
                        bitCnt_d = bitCnt_q + CNT_W'(1);
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        txd_o = 1'b1;
        pop   = 1'b0;
        unique case (state_q)
            IDLE:         pop   = !breakReq && !fifoEmpty;
            START, BREAK: txd_o = 1'b0;
            DATA:         txd_o = shift_q[0];
            PARITY:       txd_o = parity_q;
            default:      txd_o = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_cmd_tx.sv
// Directed bench for uart_cmd_tx at default parameters (8 data bits, depth 4,
// prescaler reset 3); the break section follows UART_BREAK_EN.
module tb_uart_cmd_tx;
    import uart_pkg::*;

    logic       clk;
    logic       reset;
    logic       cmdValid;
    logic       cmdReady;
    logic [1:0] cmdOp;
    logic [7:0] cmdPayload;
    logic       txd;
    logic       busy;
    logic [2:0] fifoCount;
    logic       resetStrobe;

    int vectors;
    int miscompares;

    uart_cmd_tx dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid_i    (cmdValid),
        .cmd_ready_o    (cmdReady),
        .cmd_op_i       (cmdOp),
        .cmd_payload_i  (cmdPayload),
        .txd_o          (txd),
        .busy_o         (busy),
        .fifo_count_o   (fifoCount),
        .reset_strobe_o (resetStrobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every step lands 1ns after a rising edge, where inputs change and outputs are sampled.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [7:0] payload);
        cmdValid   = 1'b1;
        cmdOp      = op;
        cmdPayload = payload;
        tick(1);
        cmdValid   = 1'b0;
        cmdOp      = CMD_DATA;
    endtask

    // Walks one frame cycle by cycle from frame cycle 'skip'; the first tick lands on that cycle.
    task automatic checkFrame(input string tag, input logic [7:0] data, input bit hasPar,
                              input bit parBit, input int stops, input int bitLen,
                              input int skip, input bit expReady);
        logic [11:0] bits;
        int          nBits;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = data[i];
        nBits = 9;
        if (hasPar) begin
            bits[9] = parBit;
            nBits   = 10;
        end
        nBits += stops;
        for (int c = skip; c < nBits * bitLen; c++) begin
            tick(1);
            checkOutput({tag, " txd"}, 32'(txd), 32'(bits[c / bitLen]));
            checkOutput({tag, " busy"}, 32'(busy), 32'd1);
            checkOutput({tag, " ready"}, 32'(cmdReady), 32'(expReady));
        end
    endtask

    initial begin
        logic [7:0] tailBytes [4];
        int         tailCounts [4];
        tailBytes  = '{8'h33, 8'h44, 8'h55, 8'h66};
        tailCounts = '{4, 3, 2, 1};
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        cmdValid    = 1'b0;
        cmdOp       = CMD_DATA;
        cmdPayload  = 8'h00;
        tick(3);
        checkOutput("rst txd", 32'(txd), 32'd1);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst count", 32'(fifoCount), 32'd0);
        checkOutput("rst strobe", 32'(resetStrobe), 32'd0);
        checkOutput("rst ready", 32'(cmdReady), 32'd1);
        reset = 1'b0;
        tick(1);

        // Basic 8N1 frame of 0xA5 with 4-cycle bits.
        applyStimulus(CMD_PREDIV, 8'd3);
        applyStimulus(CMD_DATA, 8'hA5);
        checkOutput("a5 count", 32'(fifoCount), 32'd1);
        checkOutput("a5 idle txd", 32'(txd), 32'd1);
        checkFrame("a5", 8'hA5, 1'b0, 1'b0, 1, 4, 0, 1'b1);
        tick(1);
        checkOutput("a5 busy end", 32'(busy), 32'd0);
        checkOutput("a5 txd end", 32'(txd), 32'd1);

        // Even parity, odd parity, two stop bits.
        applyStimulus(CMD_CONFIG, 8'h01);
        applyStimulus(CMD_DATA, 8'hA5);
        checkFrame("even", 8'hA5, 1'b1, 1'b0, 1, 4, 0, 1'b1);
        tick(1);
        checkOutput("even busy end", 32'(busy), 32'd0);
        applyStimulus(CMD_CONFIG, 8'h03);
        applyStimulus(CMD_DATA, 8'hA5);
        checkFrame("odd", 8'hA5, 1'b1, 1'b1, 1, 4, 0, 1'b1);
        tick(1);
        applyStimulus(CMD_CONFIG, 8'h04);
        applyStimulus(CMD_DATA, 8'hA5);
        checkFrame("stop2", 8'hA5, 1'b0, 1'b0, 2, 4, 0, 1'b1);
        tick(1);
        checkOutput("stop2 busy end", 32'(busy), 32'd0);

        // Back-to-back pushes fill the FIFO; the sixth byte stalls while full.
        applyStimulus(CMD_CONFIG, 8'h00);
        applyStimulus(CMD_DATA, 8'h11);
        cmdValid   = 1'b1;
        cmdOp      = CMD_DATA;
        cmdPayload = 8'h22;
        tick(1);
        checkOutput("b2b count1", 32'(fifoCount), 32'd1);
        checkOutput("b2b start", 32'(txd), 32'd0);
        cmdPayload = 8'h33;
        tick(1);
        checkOutput("b2b count2", 32'(fifoCount), 32'd2);
        cmdPayload = 8'h44;
        tick(1);
        checkOutput("b2b count3", 32'(fifoCount), 32'd3);
        cmdPayload = 8'h55;
        tick(1);
        checkOutput("b2b count4", 32'(fifoCount), 32'd4);
        cmdPayload = 8'h66;
        checkOutput("b2b full ready", 32'(cmdReady), 32'd0);
        checkFrame("f11", 8'h11, 1'b0, 1'b0, 1, 4, 4, 1'b0);
        tick(1);
        checkOutput("f11 idle txd", 32'(txd), 32'd1);
        checkOutput("f11 idle count", 32'(fifoCount), 32'd4);
        checkOutput("f11 idle ready", 32'(cmdReady), 32'd0);
        tick(1);
        checkOutput("f22 pop count", 32'(fifoCount), 32'd3);
        checkOutput("f22 pop ready", 32'(cmdReady), 32'd1);
        checkOutput("f22 pop txd", 32'(txd), 32'd0);
        tick(1);
        cmdValid = 1'b0;
        checkOutput("b2b refill", 32'(fifoCount), 32'd4);
        checkFrame("f22", 8'h22, 1'b0, 1'b0, 1, 4, 2, 1'b0);
        for (int f = 0; f < 4; f++) begin
            tick(1);
            checkOutput("gap txd", 32'(txd), 32'd1);
            checkOutput("gap count", 32'(fifoCount), 32'(tailCounts[f]));
            checkFrame("tail", tailBytes[f], 1'b0, 1'b0, 1, 4, 0, 1'b1);
        end
        tick(1);
        checkOutput("b2b drained busy", 32'(busy), 32'd0);
        checkOutput("b2b drained count", 32'(fifoCount), 32'd0);

        // Soft reset mid-frame: flush, abort, restore cfg and prescaler.
        applyStimulus(CMD_CONFIG, 8'h01);
        applyStimulus(CMD_PREDIV, 8'd5);
        applyStimulus(CMD_DATA, 8'h3C);
        applyStimulus(CMD_DATA, 8'h77);
        tick(8);
        checkOutput("sr pre count", 32'(fifoCount), 32'd1);
        checkOutput("sr pre busy", 32'(busy), 32'd1);
        applyStimulus(CMD_CONFIG, 8'hC0);
        checkOutput("sr strobe", 32'(resetStrobe), 32'd1);
        checkOutput("sr txd", 32'(txd), 32'd1);
        checkOutput("sr count", 32'(fifoCount), 32'd0);
        checkOutput("sr busy", 32'(busy), 32'd0);
        tick(1);
        checkOutput("sr strobe off", 32'(resetStrobe), 32'd0);
        checkOutput("sr txd idle", 32'(txd), 32'd1);
        applyStimulus(CMD_DATA, 8'hA5);
        checkFrame("sr after", 8'hA5, 1'b0, 1'b0, 1, 4, 0, 1'b1);
        tick(1);
        checkOutput("sr after busy", 32'(busy), 32'd0);

        // Prescaler change mid-frame takes effect on the next frame only.
        applyStimulus(CMD_DATA, 8'h5A);
        applyStimulus(CMD_DATA, 8'h96);
        applyStimulus(CMD_PREDIV, 8'd0);
        checkFrame("pd old", 8'h5A, 1'b0, 1'b0, 1, 4, 2, 1'b1);
        tick(1);
        checkOutput("pd gap txd", 32'(txd), 32'd1);
        checkOutput("pd gap count", 32'(fifoCount), 32'd1);
        checkFrame("pd new", 8'h96, 1'b0, 1'b0, 1, 1, 0, 1'b1);
        tick(1);
        checkOutput("pd busy end", 32'(busy), 32'd0);

        // SPARE 0x01 from IDLE: a break when built in, otherwise nothing.
        applyStimulus(CMD_PREDIV, 8'd3);
        applyStimulus(CMD_SPARE, 8'h01);
        for (int c = 0; c < 44; c++) begin
            tick(1);
`ifdef UART_BREAK_EN
            checkOutput("brk txd", 32'(txd), 32'd0);
            checkOutput("brk busy", 32'(busy), 32'd1);
`else
            checkOutput("spare txd", 32'(txd), 32'd1);
            checkOutput("spare busy", 32'(busy), 32'd0);
`endif
        end
        tick(1);
        checkOutput("brk end txd", 32'(txd), 32'd1);
        checkOutput("brk end busy", 32'(busy), 32'd0);

        // Hardware reset mid-frame wins over a simultaneous soft-reset command.
        applyStimulus(CMD_DATA, 8'hFF);
        applyStimulus(CMD_DATA, 8'h0F);
        tick(5);
        reset      = 1'b1;
        cmdValid   = 1'b1;
        cmdOp      = CMD_CONFIG;
        cmdPayload = 8'hC0;
        tick(1);
        checkOutput("hw txd", 32'(txd), 32'd1);
        checkOutput("hw count", 32'(fifoCount), 32'd0);
        checkOutput("hw busy", 32'(busy), 32'd0);
        checkOutput("hw strobe", 32'(resetStrobe), 32'd0);
        reset    = 1'b0;
        cmdValid = 1'b0;
        cmdOp    = CMD_DATA;
        tick(1);
        checkOutput("hw strobe after", 32'(resetStrobe), 32'd0);
        checkOutput("hw txd after", 32'(txd), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_cmd_tx.md
Name: uart_cmd_tx

Overview:
Command-driven, parametrised UART transmitter. It replaces the fixed 7-bit command decoder with a valid/ready command port carrying a 2-bit opcode and a DATA_W payload. Commands:
- DATA: queues a byte in an internal FIFO.
- CONFIG: sets frame format or issues a soft reset.
- PREDIV: programs the baud prescaler.
The block serialises queued bytes onto txd and sits between the TinyTapeout-style io_in command bus and the chip's serial output pin.

Parameters:
DATA_W, 8, payload width and UART data bits per frame (5..9)
DEPTH, 4, TX FIFO depth in entries (power of 2, >=2)
PREDIV_W, 8, prescaler register width
PREDIV_RST, 8'd3, prescaler reset value; bit period = prediv+1 clk cycles

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when valid&&ready
cmd_op  input  2  0=DATA, 1=CONFIG, 2=PREDIV, 3=SPARE
cmd_payload  input  DATA_W  command argument
txd  output  1  serial out, idle high
busy  output  1  frame in progress or FIFO non-empty
fifo_count  output  $clog2(DEPTH)+1  FIFO occupancy
reset_strobe  output  1  one-cycle pulse after a soft-reset command

Behaviour:
- Reset values: txd=1, busy=0, fifo_count=0, reset_strobe=0, state=IDLE, prediv=PREDIV_RST, cfg=0 (8N1, no parity). Hardware reset wins over every other event.
- cmd_ready = !(cmd_op==DATA && fifo_full). fifo_full is registered, so there is no push on a full FIFO even if a pop occurs in the same cycle. Non-DATA commands are always accepted.
- DATA: pushes cmd_payload. The push is visible in fifo_count the next cycle.
- CONFIG with payload[DATA_W-1:DATA_W-5]==5'b11000 is a soft reset:
  - reset_strobe=1 on the next cycle only.
  - Same cycle as the strobe: FIFO flushed, cfg and prediv restored to reset values, state forced to IDLE, txd=1. An in-flight frame is aborted.
- Other CONFIG: cfg <= payload[2:0].
  - bit0 = parity_en; bit1 = parity_odd; bit2 = two stop bits.
- PREDIV: prediv <= payload zero-extended or truncated to PREDIV_W.
- SPARE: accepted, no effect (see optional feature).
- cfg and prediv are latched into frame shadow registers on the IDLE->START transition. Changes made mid-frame apply to the next frame.
- Baud counter:
  - Loaded with prediv on entry to START.
  - Decrements each clk; tick when it is 0, then reloads.
  - prediv=0 gives one cycle per bit.
- FSM states and transitions:
  - IDLE: txd=1. If FIFO is non-empty: pop the head into the shift register and go to START. This is one cycle after the push is visible.
  - START: txd=0 for one bit period.
  - DATA: DATA_W bits, LSB first, one per bit period.
  - PARITY: present only if parity_en. Even parity gives a bit making the total count of ones even; odd parity inverts it.
  - STOP: txd=1 for 1 or 2 bit periods. Then go to IDLE. If the FIFO is non-empty, the next frame starts after exactly one IDLE cycle.
- busy = (state!=IDLE) || fifo_count!=0.
- FIFO pointer wrap is modulo DEPTH. fifo_count saturates logically at DEPTH because pushes are blocked when full.
- Simultaneous push and pop (not full): count unchanged, and data order is preserved.

Optional Feature:
Macro UART_BREAK_EN.
- Defined: SPARE with payload[0]=1 queues a break request. After the current frame (or immediately from IDLE), txd is held 0 for (DATA_W+3) bit periods, then returns to IDLE. busy stays high during the break. A soft reset cancels the break.
- Undefined: SPARE is a no-op and the break logic is not synthesised.

Decomposition:
- Package uart_pkg holds:
  - opcode constants CMD_DATA/CMD_CONFIG/CMD_PREDIV/CMD_SPARE
  - CMD_CONFIG_RESET=5'b11000
  - cfg bit indices
  - FSM state enum (IDLE, START, DATA, PARITY, STOP, BREAK)
- One sub-module: uart_fifo. It is a synchronous FIFO parametrised by width and depth, with full, empty and count outputs, plus a flush input.

Test Plan:
- After reset, PREDIV 3 then DATA 0xA5 -> txd from IDLE: 0,1,0,1,0,0,1,0,1,1. Each bit lasts 4 cycles; frame is 40 cycles; busy falls after the stop bit.
- CONFIG 3'b001 (even parity), DATA 0xA5 -> parity bit 0. CONFIG 3'b011 with DATA 0xA5 -> parity bit 1. CONFIG 3'b100 -> stop bit high for 8 cycles.
- Push 5 bytes back-to-back with DEPTH=4 while the first frame is running -> cmd_ready low exactly while fifo_count==4. All bytes are transmitted in order with one IDLE cycle between frames.
- CONFIG 0xC0 mid-frame -> reset_strobe high one cycle; txd=1 and fifo_count=0 in the same cycle; prediv returns to 3.
- PREDIV 0 written during a frame at prediv=3 -> current frame keeps 4-cycle bits; next frame uses 1-cycle bits.
- With UART_BREAK_EN: SPARE 0x01 while idle -> txd low for 44 cycles at prediv=3, then high. Without the macro, txd stays high.
